capture_ring_buffer: RTL

Trigger-qualified capture buffer sitting directly downstream of the 64-to-128 sample combiner. It accepts 128-bit sample words with a one-cycle valid strobe and writes them into an inferred dual-port RAM ring. It keeps a programmable pre-trigger history, collects a programmable number of post-trigger words, and then freezes. The frozen record is presented to the readout side in chronological order, oldest word first.

---
 rtl/capture_ring_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/capture_ring_buffer.sv
// capture_ring_buffer
//
// Trigger-qualified capture buffer. 128-bit sample words from the combiner
// are written into a dual-port RAM ring. A programmable pre-trigger history
// is kept, a programmable number of post-trigger words is collected, and the
// record then freezes. Readout returns the record oldest word first.
//
// Optional feature macro: CAP_TSTAMP_EN adds trig_ts, the number of writes
// between arm and the trigger cycle (saturating, latched on trigger).
//
// Ports:
//   clk        capture and readout clock
//   clr        asynchronous reset, active-high
//   din        sample word, valid while din_vld is high
//   din_vld    one-cycle write strobe
//   arm        one-cycle pulse, starts or restarts a capture
//   trig       trigger level, sampled each cycle
//   pre_len    pre-trigger words to keep (sampled on arm)
//   post_len   post-trigger words to collect (sampled on arm, 0 acts as 1)
//   busy       capture in progress (PRE, WAIT, POST)
//   done       record frozen and readable
//   trig_addr  RAM address of the first post-trigger word
//   rd_en      read request for the next record word
//   rd_data    read word, one cycle after rd_en
//   rd_valid   rd_data valid
//   rd_last    final record word
//   trig_ts    (CAP_TSTAMP_EN only) writes from arm up to the trigger cycle
//
// State | meaning
// IDLE  | nothing armed
// PRE   | filling pre-trigger history, trig ignored
// WAIT  | history full, ring keeps overwriting, waiting for trig
// POST  | collecting post-trigger words
// DONE  | record frozen, readout allowed
module capture_ring_buffer #(
    parameter int AW = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          arm,
    input  logic          trig,
    input  logic [AW:0]   pre_len,
    input  logic [AW:0]   post_len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] trig_addr,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_last
`ifdef CAP_TSTAMP_EN
    ,
    output logic [31:0]   trig_ts
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t state, nxt;

    logic [DW-1:0] mem [2**AW];

    logic [AW:0]   pl, ql, pre_cnt, post_cnt;
    // Record length pl + ql can exceed AW+1 bits, so the read counter is one
    // bit wider than the capture counters.
    logic [AW+1:0] rd_cnt, rec_len;
    logic [AW-1:0] wr_ptr, rd_ptr, cap_addr;
    logic          wr_fire, trig_fire, rd_fire, enter_done;

    assign rec_len   = {1'b0, pl} + {1'b0, ql};
    assign wr_fire   = busy && din_vld && !arm;
    assign trig_fire = (state == S_WAIT) && trig && !arm;
    assign rd_fire   = (state == S_DONE) && rd_en && !arm && (rd_cnt < rec_len);
    assign enter_done = (state != S_DONE) && (nxt == S_DONE) && !arm;
    // When the trigger and the final post write share a cycle, trig_addr is
    // not yet updated, so take the live write pointer instead.
    assign cap_addr  = (state == S_WAIT) ? wr_ptr : trig_addr;

    // state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= nxt;
    end

    // next-state logic
    always_comb begin
        nxt = state;
        if (arm) begin
            nxt = S_PRE;
        end else begin
            case (state)
                S_PRE:  if ((pl == '0) || (din_vld && (pre_cnt + (AW+1)'(1) == pl)))
                            nxt = S_WAIT;
                S_WAIT: if (trig)
                            nxt = (din_vld && (ql == (AW+1)'(1))) ? S_DONE : S_POST;
                S_POST: if (din_vld && (post_cnt + (AW+1)'(1) == ql))
                            nxt = S_DONE;
                default: nxt = state;
            endcase
        end
    end

    // outputs
    always_comb begin
        busy = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
        done = (state == S_DONE);
    end

    // capture and readout datapath
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pl        <= '0;
            ql        <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            rd_cnt    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trig_addr <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            rd_last  <= rd_fire && (rd_cnt + (AW+2)'(1) == rec_len);
            if (rd_fire) rd_data <= mem[rd_ptr];

            if (arm) begin
                pl       <= pre_len;
                ql       <= (post_len == '0) ? (AW+1)'(1) : post_len;
                pre_cnt  <= '0;
                post_cnt <= '0;
                rd_cnt   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
                if ((state == S_PRE) && din_vld) pre_cnt <= pre_cnt + (AW+1)'(1);

                if (trig_fire) begin
                    trig_addr <= wr_ptr;
                    post_cnt  <= din_vld ? (AW+1)'(1) : '0;
                end else if ((state == S_POST) && din_vld) begin
                    post_cnt <= post_cnt + (AW+1)'(1);
                end

                // Oldest retained word sits pl slots behind the trigger word.
                if (enter_done) begin
                    rd_ptr <= cap_addr - pl[AW-1:0];
                    rd_cnt <= '0;
                end else if (rd_fire) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    rd_cnt <= rd_cnt + (AW+2)'(1);
                end
            end
        end
    end

    // RAM write port, contents are never reset
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= din;
    end

`ifdef CAP_TSTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ts_cnt  <= '0;
            trig_ts <= '0;
        end else if (arm) begin
            ts_cnt  <= '0;
            trig_ts <= '0;
        end else begin
            if (wr_fire && (ts_cnt != '1)) ts_cnt <= ts_cnt + 32'd1;
            // ts_cnt excludes the trigger-cycle write since it updates after
            if (trig_fire) trig_ts <= ts_cnt;
        end
    end
`endif

endmodule
